// File: rtl/rr_decode_arbiter_if.sv
// Purpose: request/grant bundle between 32 requesters and the round-robin decode arbiter.
// Latency: none, wires only.
// Backpressure: none; requests are level-held and the owner ends its grant with release_i.
interface rr_decode_arbiter_if #(
  parameter int N     = 32,
  parameter int IDX_W = 5
);
  logic [N-1:0]     req_i;
  logic             release_i;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic [N-1:0]     grant_onehot_o;
  logic             timeout_o;

  // Requester side drives requests and release, observes the grant.
  modport master (
    output req_i, release_i,
    input  grant_valid_o, grant_idx_o, grant_onehot_o, timeout_o
  );

  // Arbiter side.
  modport slave (
    input  req_i, release_i,
    output grant_valid_o, grant_idx_o, grant_onehot_o, timeout_o
  );
endinterface

// File: rtl/rr_decode_arbiter.sv
// Purpose: round-robin arbiter granting one of 32 requesters a decoded one-hot select line.
// Latency: 1 cycle from request sampled in IDLE to grant visible; at least one IDLE cycle between grants.
// Backpressure: grant held until release, request drop or MAX_HOLD timeout; other requesters wait.
module rr_decode_arbiter #(
  parameter int N        = 32,
  parameter int IDX_W    = 5,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  rr_decode_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic             vld_q;
  logic             to_q;
  logic [N-1:0]     oh_q;

  logic             win_found_d;
  logic [IDX_W-1:0] win_idx_d;
  logic [IDX_W-1:0] cand_d;
  logic [N-1:0]     win_oh_d;
  logic             rel_end_d;
  logic             drop_end_d;
  logic             hold_end_d;
  logic             end_grant_d;

  // Search upward from the slot after the last owner, wrapping; first set request wins.
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    for (int k = 0; k < N; k++) begin
      cand_d = ptr_q + IDX_W'(k + 1);
      if (!win_found_d && bus.req_i[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
  end

  // Decode the next owner so the one-hot register loads together with the index.
  always_comb begin
    win_oh_d = {{(N-1){1'b0}}, 1'b1} << win_idx_d;
  end

  // Grant end conditions; release and request drop take precedence over timeout.
  always_comb begin
    rel_end_d   = bus.release_i;
    drop_end_d  = !bus.req_i[idx_q];
    hold_end_d  = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));
    end_grant_d = rel_end_d || drop_end_d || hold_end_d;
  end

  // Arbiter FSM with registered outputs; ptr starts at N-1 so the first search begins at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      idx_q   <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      to_q    <= 1'b0;
      oh_q    <= '0;
    end else begin
      to_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found_d) begin
            state_q <= GRANT;
            vld_q   <= 1'b1;
            idx_q   <= win_idx_d;
            oh_q    <= win_oh_d;
            cnt_q   <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (end_grant_d) begin
            state_q <= IDLE;
            ptr_q   <= idx_q;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            oh_q    <= '0;
            cnt_q   <= '0;
            to_q    <= hold_end_d && !rel_end_d && !drop_end_d;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.grant_valid_o  = vld_q;
  assign bus.grant_idx_o    = idx_q;
  assign bus.grant_onehot_o = oh_q;
  assign bus.timeout_o      = to_q;

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Sequential round-robin arbiter that shares one decoded resource (a 32-line select bus) among 32 requesters.
- Picks one requester and registers its 5-bit index, then drives the matching one-hot line through a 5-to-32 decode. Only one line is ever high.
- Holds the grant until release, request drop, or hold timeout, then rotates priority.
- Sits in front of any 32-way select/enable fabric built on the decoder tree.

Parameters:
- N, 32, number of requesters; fixed at 32, equal to 2**IDX_W.
- IDX_W, 5, width of the grant index.
- MAX_HOLD, 16, maximum grant duration in cycles; 0 disables the timeout.
- CNT_W, 8, width of the hold counter; MAX_HOLD must be < 2**CNT_W.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  32  request vector; bit i is requester i. Level-sensitive.
- release  input  1  single-cycle pulse from the current owner to end its grant.
- grant_valid  output  1  a grant is currently held.
- grant_idx  output  5  index of the current owner; 0 when grant_valid=0.
- grant_onehot  output  32  decoded grant; bit grant_idx high only when grant_valid=1, otherwise all 0.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant_valid=0, grant_idx=0, grant_onehot=0, timeout=0.
  - hold counter=0, last-owner pointer ptr=31, so the first search starts at index 0.
- States: IDLE, GRANT.
- IDLE:
  - Each cycle, search req starting at (ptr+1) mod 32 and going upward with wrap-around.
  - The first set bit wins.
  - If any bit is set: next cycle state=GRANT, grant_valid=1, grant_idx=winner, counter=1. Latency is 1 cycle from req sampled to grant visible.
  - If req=0: remain in IDLE, outputs stay 0.
- GRANT ends on the first of these, checked at the rising edge:
  - (a) release=1.
  - (b) req[grant_idx]=0.
  - (c) MAX_HOLD!=0 and counter==MAX_HOLD.
- When any end condition fires:
  - ptr<=grant_idx, state<=IDLE, grant_valid<=0, grant_idx<=0, counter<=0.
  - For (c) only, and only if (a) and (b) are both false, timeout<=1 for exactly that one cycle.
  - Otherwise counter increments, saturating at 2**CNT_W-1.
- Bubble: there is always at least one IDLE cycle between consecutive grants, including the same requester regaining the grant. Minimum grant period is 2 cycles.
- Priority after a grant ends: the previous owner has lowest priority. A requester that is continuously requesting waits at most 31 grants.
- grant_onehot is a registered output decoded from the next-state index. It changes in the same cycle as grant_idx, with no glitch cycle where two bits are high.
- Ignored and illegal inputs:
  - release while IDLE is ignored.
  - Changes on req bits other than grant_idx during GRANT are ignored.
- Reset asserted mid-GRANT: outputs clear immediately (asynchronously) and ptr returns to 31.
- Simultaneous release and timeout: treated as release; timeout stays 0.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. timeout pulses on each grant unless the grant ends by (a) or (b).

Test Plan:
- Reset then req=32'h0000_0001: grant_valid=1 and grant_idx=0 one cycle later, grant_onehot=32'h1. Release pulse, then IDLE for 1 cycle and grant_idx=0 again.
- Rotation:
  - Stimulus: req=32'h8000_0011 held; release pulsed each time a grant is seen.
  - Required: grant order 0, 4, 31, 0, each grant separated by one IDLE cycle.
  - Required: grant_onehot matches 32'h1, 32'h10, 32'h8000_0000.
- Timeout, MAX_HOLD=4:
  - Stimulus: req=32'h0000_0100 held with no release.
  - Required: grant_idx=8 for exactly 4 cycles, then timeout=1 for 1 cycle with grant_valid=0.
  - Required: grant is retaken on the following cycle.
- Request drop: grant to idx 5, then drop req[5] mid-grant. Next cycle grant_valid=0, timeout=0, ptr=5, so req=32'h21 next grants idx 5 only after idx... no: grants idx 0 first (search starts at 6, wraps to 0).
- Async reset mid-grant: assert rst between clock edges while grant_idx=17. grant_valid, grant_onehot and grant_idx go to 0 without a clock edge. After release of reset with req=32'h0002_0001, grant_idx=0.
- Simultaneous events, MAX_HOLD=3:
  - Stimulus: release asserted in the same cycle the counter hits 3.
  - Required: timeout stays 0 and the grant ends normally.
  - Required throughout every scenario: at most one bit of grant_onehot is ever set.
